// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: binary value -> BCD (sequential double-dabble) ->
// time-multiplexed DIGITS-wide seven-segment display with optional
// leading-zero blanking and overflow saturation.
//
// Handshake: load/busy behave as valid/ready with ready = !busy. A transfer
// happens on any rising edge where load=1 and busy=0; value is sampled on
// that edge. A load while busy=1 is dropped, not held or queued. done is a
// one-cycle pulse on the edge the new digits are committed, which is also
// the edge busy falls, so a new load may be presented while done is high.
module seven_seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BIN_W-1:0]  value,
  input  logic              blank_lz,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [DIGITS-1:0] anode,
  output logic [7:0]        segments
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Largest value the display can show; larger inputs saturate to it.
  localparam logic [31:0] MAX_DEC = 32'(pow10(DIGITS) - 1);

  // Team segment code for one BCD digit; non-decimal nibbles show nothing.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hEB;
      4'd1:    s = 8'h28;
      4'd2:    s = 8'hB3;
      4'd3:    s = 8'hBA;
      4'd4:    s = 8'h78;
      4'd5:    s = 8'hDA;
      4'd6:    s = 8'hDB;
      4'd7:    s = 8'hA8;
      4'd8:    s = 8'hFB;
      4'd9:    s = 8'hFA;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift
  // {bcd, bin} left by one.
  function automatic logic [BCD_W+BIN_W-1:0] dd_step(
    input logic [BCD_W-1:0] b,
    input logic [BIN_W-1:0] v
  );
    logic [BCD_W-1:0] adj;
    adj = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj, v} << 1;
  endfunction

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                  state, state_next;
  logic                    accept, last_iter;
  logic                    sat;
  logic [CNT_W-1:0]        bit_cnt;
  logic [BIN_W-1:0]        bin;
  logic [BCD_W-1:0]        bcd;
  logic [BCD_W+BIN_W-1:0]  step;
  logic                    ovf_flag;
  logic [BCD_W-1:0]        digits;
  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [DIGITS-1:0]       blank;
  logic                    zero_above;
  logic [7:0]              seg_next;

  assign busy = (state == S_SHIFT);
  assign sat  = ({{(32-BIN_W){1'b0}}, value} > MAX_DEC);

  // Engine state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Engine next-state: accept in IDLE, leave SHIFT after BIN_W iterations.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_iter  = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          accept     = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_cnt == CNT_W'(BIN_W - 1)) begin
          last_iter  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Next {bcd, bin} after one conversion iteration.
  always_comb step = dd_step(bcd, bin);

  // Conversion datapath and commit of the finished BCD into the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin      <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      ovf_flag <= 1'b0;
      digits   <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        bin      <= sat ? MAX_DEC[BIN_W-1:0] : value;
        bcd      <= '0;
        bit_cnt  <= '0;
        ovf_flag <= sat;
      end else if (state == S_SHIFT) begin
        {bcd, bin} <= step;
        bit_cnt    <= bit_cnt + CNT_W'(1);
        if (last_iter) begin
          digits <= step[BCD_W+BIN_W-1 -: BCD_W];
          ovf    <= ovf_flag;
          done   <= 1'b1;
        end
      end
    end
  end

  // Scan divider and digit index, free-running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Leading-zero mask: digit i>0 blanks when it and everything above is 0.
  always_comb begin
    blank      = '0;
    zero_above = blank_lz;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (digits[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end

  // Segment pattern for the currently indexed digit.
  always_comb begin
    seg_next = seg_code(digits[4*idx +: 4]);
    if (blank[idx]) seg_next = 8'h00;
  end

  // Registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode    <= DIGITS'(1);
      segments <= 8'hEB;
    end else begin
      anode    <= DIGITS'(1) << idx;
      segments <= seg_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Testbench for seven_seg_scan_driver (DIGITS=4, BIN_W=14, SCAN_DIV=4).
module tb_seven_seg_scan_driver;

  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;
  localparam int MAXV     = 9999;
  localparam int PERIOD   = DIGITS * SCAN_DIV;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [BIN_W-1:0]  value;
  logic              blank_lz;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [DIGITS-1:0] anode;
  logic [7:0]        segments;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          v;
    bit          blk;
    logic [31:0] segs;  // digit i pattern at [8*i +: 8]
    bit          ovf;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] exp_q[$];
  logic [7:0]  seg_tab [10];

  // Clock and DUT.
  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
    .busy(busy), .done(done), .ovf(ovf), .anode(anode), .segments(segments)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: saturate, split into decimal digits arithmetically, blank a
  // digit above 0 when the whole shown number is below its place value.
  function automatic logic [31:0] model_segs(input int v, input bit blk);
    int s;
    int p;
    logic [31:0] r;
    s = (v > MAXV) ? MAXV : v;
    p = 1;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!(blk && i > 0 && s < p)) r[8*i +: 8] = seg_tab[(s / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  // Presents a load at the current falling edge, then waits (bounded) for
  // done; returns positioned at the falling edge where done is high.
  task automatic convert(input int v, input string tag);
    int busy_n;
    bit got;
    load  = 1'b1;
    value = BIN_W'(v);
    @(negedge clk);
    load  = 1'b0;
    value = BIN_W'($urandom);
    busy_n = 0;
    got    = 1'b0;
    for (int c = 0; c < BIN_W + 4 && !got; c++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) busy_n++;
        @(negedge clk);
      end
    end
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " busy_len"}, 32'(busy_n), 32'(BIN_W));
    check({tag, " busy_low_at_done"}, 32'(busy), 32'd0);
  endtask

  // Watches one full refresh period and checks every digit shown.
  task automatic check_display(input logic [31:0] exp, input string tag);
    int cnt [DIGITS];
    int id;
    for (int d = 0; d < DIGITS; d++) cnt[d] = 0;
    @(negedge clk);
    check({tag, " done_single"}, 32'(done), 32'd0);
    for (int j = 0; j < PERIOD; j++) begin
      if (j > 0) @(negedge clk);
      check({tag, " onehot"}, 32'($onehot(anode)), 32'd1);
      id = 0;
      for (int d = DIGITS - 1; d >= 0; d--) if (anode[d]) id = d;
      cnt[id]++;
      check($sformatf("%s seg_d%0d", tag, id), 32'(segments), 32'(exp[8*id +: 8]));
    end
    for (int d = 0; d < DIGITS; d++)
      check($sformatf("%s dwell_d%0d", tag, d), 32'(cnt[d]), 32'(SCAN_DIV));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    logic [DIGITS-1:0] prev;
    bit found;
    int dn;
    int v;
    bit blk;

    seg_tab = '{8'hEB, 8'h28, 8'hB3, 8'hBA, 8'h78, 8'hDA, 8'hDB, 8'hA8, 8'hFB, 8'hFA};
    vecs[0] = '{1234,  1'b0, 32'h28B3BA78, 1'b0};
    vecs[1] = '{9999,  1'b0, 32'hFAFAFAFA, 1'b0};
    vecs[2] = '{10000, 1'b0, 32'hFAFAFAFA, 1'b1};
    vecs[3] = '{16383, 1'b0, 32'hFAFAFAFA, 1'b1};
    vecs[4] = '{7,     1'b1, 32'h000000A8, 1'b0};
    vecs[5] = '{0,     1'b1, 32'h000000EB, 1'b0};
    vecs[6] = '{1005,  1'b1, 32'h28EBEBDA, 1'b0};
    vecs[7] = '{0,     1'b0, 32'hEBEBEBEB, 1'b0};
    vecs[8] = '{100,   1'b1, 32'h0028EBEB, 1'b0};
    vecs[9] = '{42,    1'b0, 32'hEBEB78B3, 1'b0};

    // Reset state.
    rst = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    check("rst anode", 32'(anode), 32'd1);
    check("rst segments", 32'(segments), 32'hEB);
    rst = 1'b0;
    @(negedge clk);

    // Scan order and dwell for 1234.
    convert(1234, "scan");
    check("scan ovf", 32'(ovf), 32'd0);
    prev  = anode;
    found = 1'b0;
    for (int c = 0; c < 3 * PERIOD && !found; c++) begin
      @(negedge clk);
      if (anode == DIGITS'(1) && prev != DIGITS'(1)) found = 1'b1;
      prev = anode;
    end
    check("scan run_start", 32'(found), 32'd1);
    for (int j = 0; j < PERIOD; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("scan anode_%0d", j), 32'(anode), 32'(DIGITS'(1) << (j / SCAN_DIV)));
      check($sformatf("scan seg_%0d", j), 32'(segments), 32'(vecs[0].segs[8*(j/SCAN_DIV) +: 8]));
    end

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      blank_lz = vecs[i].blk;
      @(negedge clk);
      convert(vecs[i].v, $sformatf("vec%0d", i));
      check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      check_display(vecs[i].segs, $sformatf("vec%0d", i));
    end

    // Load during busy is dropped.
    blank_lz = 1'b0;
    @(negedge clk);
    load = 1'b1; value = BIN_W'(42);
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    load = 1'b1; value = BIN_W'(99);
    @(negedge clk);
    load = 1'b0;
    dn = 0;
    for (int c = 0; c < BIN_W + 8; c++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("ign done_count", 32'(dn), 32'd1);
    check("ign busy", 32'(busy), 32'd0);
    check_display(model_segs(42, 1'b0), "ign");

    // Back-to-back: second load on the edge where done is high.
    @(negedge clk);
    convert(111, "b2b_a");
    convert(222, "b2b_b");
    check_display(model_segs(222, 1'b0), "b2b");

    // Reset mid-conversion after an overflowed value is shown.
    @(negedge clk);
    convert(16383, "pre_rst");
    check("pre_rst ovf", 32'(ovf), 32'd1);
    @(negedge clk);
    load = 1'b1; value = BIN_W'(1234);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ovf", 32'(ovf), 32'd0);
    check("midrst anode", 32'(anode), 32'd1);
    check("midrst segments", 32'(segments), 32'hEB);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < BIN_W + 4; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("midrst no_done", 32'(dn), 32'd0);
    check("midrst busy_after", 32'(busy), 32'd0);
    check_display(model_segs(0, blank_lz), "midrst");

    // Randomized conversions against the reference model.
    for (int n = 0; n < 250; n++) begin
      v   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9990, 16383))
                                        : int'($urandom_range(0, 9999));
      blk = 1'($urandom_range(0, 1));
      blank_lz = blk;
      @(negedge clk);
      exp_q.push_back(model_segs(v, blk));
      convert(v, $sformatf("rnd%0d v=%0d", n, v));
      check($sformatf("rnd%0d ovf", n), 32'(ovf), 32'(v > MAXV));
      e = exp_q.pop_front();
      check_display(e, $sformatf("rnd%0d v=%0d blk=%0d", n, v, blk));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Parametrised successor to the single-digit BCD-to-segment decoder. It accepts a binary value, converts it to BCD sequentially with a shift-add-3 (double-dabble) engine, and drives a time-multiplexed DIGITS-wide seven-segment display. Digits use the team's 8-bit segment code, with optional leading-zero blanking and overflow saturation. It sits between the spectrum-analysis core, which supplies values, and the board display pins.

## Interface
- DIGITS, 4: number of display digits (1–8); digit 0 is least significant.
- BIN_W, 14: width of the binary input (1–27).
- SCAN_DIV, 50000: clock cycles each digit stays selected (≥2).
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- load  in  1  request to convert `value`; accepted only when busy=0.
- value  in  BIN_W  unsigned binary value, sampled on accepted load.
- blank_lz  in  1  1 = blank leading zeros (level, read every cycle).
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when the new digits are committed.
- ovf  out  1  last accepted value exceeded 10^DIGITS−1; held until next commit.
- anode  out  DIGITS  one-hot digit select, active-high.
- segments  out  8  segment pattern for the selected digit.

## Operation
- Segment codes (hex), BCD 0–9: EB, 28, B3, BA, 78, DA, DB, A8, FB, FA. Codes A–F and blanked digits: 00.
- **Accept**
  - A load is accepted when load=1 and busy=0.
  - If value > 10^DIGITS−1, the engine loads 10^DIGITS−1 instead and sets an internal overflow flag.
  - The comparison is full-width unsigned.
- **Engine FSM: IDLE → SHIFT → IDLE**
  - SHIFT runs exactly BIN_W iterations, tracked by a bit counter.
  - Each iteration: first add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1.
- **Commit**
  - On the final iteration edge, the BCD result is written to the display digit registers and ovf takes the flag.
  - done pulses and busy falls on that same edge.
  - The display registers change only at commit, so the display never shows partial results.
- Load while busy=1 is ignored: no queueing, no effect on the conversion in flight.
- **Scan**
  - The divider counts 0..SCAN_DIV−1. At terminal count it wraps to 0 and the digit index advances; after DIGITS−1 it wraps to 0.
  - The scan runs continuously, independent of the engine.
- **Output stage** (registered, updated every cycle)
  - anode = one-hot of the index.
  - segments = code of digit[index], or 00 if that digit is blanked.
- **Blanking**
  - With blank_lz=1, digit i (i>0) is blanked if digits i..DIGITS−1 are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- **Reset**
  - Asynchronous: digits all 0, FSM IDLE, counters 0, index 0.
  - busy=0, done=0, ovf=0, anode=1 (digit 0), segments=EB.
  - A reset during SHIFT aborts the conversion. No done pulse, no commit.

## Timing
- Load accepted at edge k: busy=1 from edge k through edge k+BIN_W−1, then busy=0 and done=1 after edge k+BIN_W.
- Committed digits reach segments/anode no later than edge k+BIN_W+1 (one cycle of output register latency).
- A new load may be accepted on the edge where done is high (busy already 0). Back-to-back throughput is one conversion per BIN_W+1 cycles.
- Each digit is selected for exactly SCAN_DIV cycles. The full refresh period is DIGITS·SCAN_DIV cycles.
- anode and segments change on the same edge, one cycle after the index changes. Exactly one anode bit is high at all times after reset.
- blank_lz takes effect one cycle after it changes.
- Commit while a digit is selected: segments update on the following edge with the new digit value. The anode does not change.

## Test plan
- Reset mid-SHIFT (assert rst two cycles after load of 1234) → busy=0, ovf=0, anode=0001, segments=EB immediately; no done pulse follows.
- DIGITS=4, BIN_W=14, SCAN_DIV=4: load value 1234 → busy high 14 cycles, then done pulses once. Scan then shows anode 0001/0010/0100/1000 with segments 78/BA/B3/28, 4 cycles each.
- Load 9999, then load 10000 and 16383 → 9999 gives ovf=0 and shows FA on all digits. 10000 and 16383 each give ovf=1 and show FA on all digits.
- Load 7 with blank_lz=1 → digit0 shows A8, digits 1–3 show 00. Load 0 → digit0 shows EB, others 00. Load 1005 → 28, EB, EB, DA (digits 3..0); no blanking, since zeros are interior.
- Load 42, then pulse load=1 with value 99 during busy → the second load is ignored. Commit shows 42. A single done pulse occurs.
- Sweep all values 0–9999 with blank_lz=0 → each digit's segments matches the code table for the decimal digit; no 00 appears on any digit.
